lfsr_seq_checker: RTL
=====================

# lfsr_seq_checker

Serial sequence checker that sits directly downstream of the 4-bit Fibonacci LFSR and consumes its single-bit output stream. It rebuilds the generator state from the incoming bits and then predicts every following bit. It reports lock status, per-bit errors and a saturating error count, so the generator can be checked on silicon and in simulation. The check is self-synchronising: no seed or shared state has to be passed from the generator.

## Interface
- `WIDTH`, 4: generator register width; the history window has the same width.
- `TAPS`, 4'b1001: feedback mask; the predicted bit is XOR of (window & TAPS).
- `LOCK_CNT`, 8: consecutive correct predictions required to declare lock.
- `WIN_LEN`, 16: length of the loss-of-lock observation window, in valid bits.
- `ERR_LIMIT`, 4: number of errors within one window that forces loss of lock.
- `CNT_W`, 16: width of `err_count`.

Ports:
- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `bit_in` input 1: serial bit from the generator (its LSB).
- `bit_valid` input 1: qualifies `bit_in`; bits are ignored while it is low.
- `clr_err` input 1: synchronous clear of `err_count` and `stuck`.
- `locked` output 1: high while in state LOCKED.
- `err_pulse` output 1: one-cycle pulse for each mispredicted bit while LOCKED.
- `lost_pulse` output 1: one-cycle pulse on the LOCKED→HUNT transition.
- `stuck` output 1: sticky flag, set when an all-zero window is detected.
- `err_count` output CNT_W: saturating count of errors while LOCKED.

## Operation
- Window `h`:
  - Each valid bit updates it as h <= {new, h[WIDTH-1:1]}, so the oldest bit is at h[0].
  - Prediction: pred = ^(h & TAPS).
- The FSM has three states: HUNT, VERIFY and LOCKED.
- **HUNT** (the reset state)
  - Each valid bit shifts `bit_in` into the window and increments `fill_cnt`.
  - On the WIDTH-th bit, if the new window is nonzero: go to VERIFY with match_cnt=0.
  - On the WIDTH-th bit, if the new window is all zero: set `stuck`, clear `fill_cnt`, stay in HUNT.
- **VERIFY**
  - Each valid bit shifts in `bit_in` (the actual bit). This is the self-sync step.
  - If bit_in == pred: increment match_cnt. When match_cnt reaches LOCK_CNT, go to LOCKED with win_idx=0 and win_err=0.
  - If bit_in != pred: match_cnt=0 and stay in VERIFY. No error is counted.
  - If the new window is all zero: set `stuck` and go to HUNT. This takes priority over the other VERIFY transitions.
- **LOCKED**
  - Each valid bit shifts in `pred` (free-running), so a single line error produces exactly one error.
  - A mismatch raises `err_pulse`, increments `err_count` (saturating at all-ones) and increments `win_err`.
  - `win_idx` counts valid bits from 0 to WIN_LEN-1 and wraps.
  - When win_err reaches ERR_LIMIT: go to HUNT (fill_cnt=0), assert `lost_pulse`, drop `locked`.
  - On the last bit of a window, `win_err` clears. If the limit is reached on that same bit, the unlock takes priority.
- `clr_err`:
  - Takes priority over an increment in the same cycle: the count becomes 0 and that error is not counted.
  - Clears `stuck`, unless `stuck` is being set in the same cycle, in which case set wins.
  - Has no effect on the FSM.
- `bit_valid` low: the state, window and counters hold, and both pulses are low.

## Timing
- All outputs are registered. The reset value of every output and internal register is 0, and the state is HUNT.
- Latency: `err_pulse` and `lost_pulse` go high in the cycle after the edge that samples the offending valid bit.
- `locked` rises in the cycle after the LOCK_CNT-th matching bit is sampled. With `bit_valid` high continuously, this is WIDTH+LOCK_CNT (12) valid bits after reset release.
- Asserting `rst_n` mid-stream returns the block to HUNT immediately and drops all outputs asynchronously.

## Configuration
- `LFSR_CHK_ERRCNT_EN`
  - Defined: the `err_count` register and its `clr_err` handling are built as described.
  - Undefined: `err_count` is tied to 0 and no counter flops exist. `err_pulse`, `stuck` and lock behaviour are unchanged, and `clr_err` still clears `stuck`.

## Structure
- Package `lfsr_chk_pkg` holds:
  - the state enum (HUNT, VERIFY, LOCKED);
  - the default TAPS constant 4'b1001;
  - the default WIDTH constant.
- Sub-module `lfsr_chk_sat_cnt`: parameterised saturating counter with synchronous clear (clear priority) and increment enable. It is used for `err_count`.

## Test plan
- **Clean lock.** Generator reset to 0110 drives the continuous stream 0,1,1,0,0,1,0,0,0,1,1,1,1,0,1 (period 15) with `bit_valid` high.
  - Required: `locked`=1 in the cycle after the 12th bit, and it stays high.
  - Required: `err_count`=0 and `err_pulse` never asserts over 100 bits.
- **Single bit error.** After lock, invert one bit.
  - Required: exactly one `err_pulse`, `err_count`=1, `locked` stays 1.
- **Loss of lock.** After lock, invert 4 bits within one 16-bit window.
  - Required: one `lost_pulse` after the 4th error, `locked`=0, `err_count`=4.
  - Required: relock occurs 12 valid bits later.
- **Window boundary.** Inject 3 errors at the end of one window and 3 at the start of the next.
  - Required: no loss of lock, `err_count`=6.
- **All-zero input.** Drive a constant-zero stream from reset.
  - Required: `stuck`=1 after the 4th bit, `locked` stays 0.
  - Required: `clr_err` clears `stuck` for one cycle, then it is set again after the next 4 zero bits.
- **Gaps, clear and reset.**
  - Toggle `bit_valid` every cycle during lock: `locked` is delayed to 12 valid bits (24 cycles).
  - Assert `clr_err` together with an error: `err_count` reads 0.
  - Pull `rst_n` low while LOCKED: all outputs go to 0 asynchronously.

Source files
------------

// File: rtl/lfsr_chk_pkg.sv
// ============================================================================
// Module   : lfsr_chk_pkg
// Purpose  : Shared types and default constants for the LFSR sequence checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_chk_pkg;

  // Checker synchronisation state
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Default generator geometry: 4-bit Fibonacci LFSR, x^4 + x^3 + 1
  localparam int         DEF_WIDTH = 4;
  localparam logic [3:0] DEF_TAPS  = 4'b1001;

endpackage : lfsr_chk_pkg

`default_nettype wire

// File: rtl/lfsr_chk_sat_cnt.sv
// ============================================================================
// Module   : lfsr_chk_sat_cnt
// Purpose  : Saturating up-counter with synchronous clear (clear wins over
//            increment) and increment enable. Built only when
//            LFSR_CHK_ERRCNT_EN is defined; otherwise the design has no
//            error counter at all.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef LFSR_CHK_ERRCNT_EN
module lfsr_chk_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then increment unless already all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : lfsr_chk_sat_cnt
`endif

`default_nettype wire

// File: rtl/lfsr_seq_checker.sv
// ============================================================================
// Module   : lfsr_seq_checker
// Purpose  : Self-synchronising checker for a serial Fibonacci LFSR stream.
//            Rebuilds the generator state from received bits, verifies it,
//            then free-runs and flags every mispredicted bit.
// Config   : LFSR_CHK_ERRCNT_EN - when defined, builds the saturating
//            err_count register; otherwise err_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_seq_checker
  import lfsr_chk_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS      = DEF_TAPS,
  parameter int               LOCK_CNT  = 8,
  parameter int               WIN_LEN   = 16,
  parameter int               ERR_LIMIT = 4,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             lost_pulse,
  output logic             stuck,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W  = $clog2(WIDTH) + 1;
  localparam int MATCH_W = $clog2(LOCK_CNT) + 1;
  localparam int IDX_W   = $clog2(WIN_LEN) + 1;
  localparam int WERR_W  = $clog2(ERR_LIMIT) + 1;

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(WIN_LEN - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(ERR_LIMIT - 1);

  chk_state_e         state_q;
  logic [WIDTH-1:0]   h_q;          // history window, oldest bit at [0]
  logic [FILL_W-1:0]  fill_cnt_q;
  logic [MATCH_W-1:0] match_cnt_q;
  logic [IDX_W-1:0]   win_idx_q;
  logic [WERR_W-1:0]  win_err_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic               lost_pulse_q;
  logic               stuck_q;

  logic               pred;
  logic               mismatch;
  logic [WIDTH-1:0]   h_act;        // window with the received bit shifted in
  logic [WIDTH-1:0]   h_pred;       // window with the predicted bit shifted in
  logic               stuck_set;

  assign pred     = ^(h_q & TAPS);
  assign mismatch = bit_in ^ pred;
  assign h_act    = {bit_in, h_q[WIDTH-1:1]};
  assign h_pred   = {pred, h_q[WIDTH-1:1]};

  // An all-zero window can never come from a running LFSR; it is only
  // looked for where the window is built from received bits.
  assign stuck_set = bit_valid && (h_act == '0) &&
                     (((state_q == HUNT) && (fill_cnt_q == FILL_LAST)) ||
                      (state_q == VERIFY));

  // Synchronisation FSM with window, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      h_q          <= '0;
      fill_cnt_q   <= '0;
      match_cnt_q  <= '0;
      win_idx_q    <= '0;
      win_err_q    <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      lost_pulse_q <= 1'b0;
    end else begin
      err_pulse_q  <= 1'b0;
      lost_pulse_q <= 1'b0;
      if (bit_valid) begin
        case (state_q)
          HUNT: begin
            h_q <= h_act;
            if (fill_cnt_q == FILL_LAST) begin
              fill_cnt_q <= '0;
              if (h_act != '0) begin
                state_q     <= VERIFY;
                match_cnt_q <= '0;
              end
            end else begin
              fill_cnt_q <= fill_cnt_q + FILL_W'(1);
            end
          end
          VERIFY: begin
            // The received bit always enters the window: this is what lets
            // the checker pull itself onto the generator's phase.
            h_q <= h_act;
            if (h_act == '0) begin
              state_q    <= HUNT;
              fill_cnt_q <= '0;
            end else if (!mismatch) begin
              if (match_cnt_q == MATCH_LAST) begin
                state_q     <= LOCKED;
                locked_q    <= 1'b1;
                match_cnt_q <= '0;
                win_idx_q   <= '0;
                win_err_q   <= '0;
              end else begin
                match_cnt_q <= match_cnt_q + MATCH_W'(1);
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
          LOCKED: begin
            // Free-run on the prediction so one line error costs one error.
            h_q         <= h_pred;
            err_pulse_q <= mismatch;
            if (mismatch && (win_err_q == WERR_LAST)) begin
              state_q      <= HUNT;
              fill_cnt_q   <= '0;
              locked_q     <= 1'b0;
              lost_pulse_q <= 1'b1;
              win_idx_q    <= '0;
              win_err_q    <= '0;
            end else if (win_idx_q == IDX_LAST) begin
              win_idx_q <= '0;
              win_err_q <= '0;
            end else begin
              win_idx_q <= win_idx_q + IDX_W'(1);
              win_err_q <= win_err_q + WERR_W'(mismatch);
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky all-zero flag: a new detection beats a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_q <= 1'b0;
    end else if (stuck_set) begin
      stuck_q <= 1'b1;
    end else if (clr_err) begin
      stuck_q <= 1'b0;
    end
  end

`ifdef LFSR_CHK_ERRCNT_EN
  logic err_inc;

  assign err_inc = bit_valid && (state_q == LOCKED) && mismatch;

  lfsr_chk_sat_cnt #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_err),
    .inc_i (err_inc),
    .cnt_o (err_count)
  );
`else
  assign err_count = '0;
`endif

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign lost_pulse = lost_pulse_q;
  assign stuck      = stuck_q;

endmodule : lfsr_seq_checker

`default_nettype wire
